// File: rtl/game_pkg.sv
// game_pkg: shared orientation codes, vertical state enum and BotInfo field layout
package game_pkg;

    localparam logic [2:0] ORIENT_N  = 3'd0;
    localparam logic [2:0] ORIENT_NE = 3'd1;
    localparam logic [2:0] ORIENT_E  = 3'd2;
    localparam logic [2:0] ORIENT_SE = 3'd3;
    localparam logic [2:0] ORIENT_S  = 3'd4;
    localparam logic [2:0] ORIENT_SW = 3'd5;
    localparam logic [2:0] ORIENT_W  = 3'd6;
    localparam logic [2:0] ORIENT_NW = 3'd7;

    localparam int MOVE_MSB   = 7;
    localparam int MOVE_LSB   = 4;
    localparam int AIR_BIT    = 3;
    localparam int ORIENT_MSB = 2;
    localparam int ORIENT_LSB = 0;

    typedef enum logic [1:0] {
        GROUNDED = 2'd0,
        RISING   = 2'd1,
        FALLING  = 2'd2
    } vstate_t;

    // Sprite heading: airborne states tilt the facing direction up or down.
    function automatic logic [2:0] orient_code(input vstate_t state, input logic facing_left);
        return (state == RISING)  ? (facing_left ? ORIENT_NW : ORIENT_NE) :
               (state == FALLING) ? (facing_left ? ORIENT_SW : ORIENT_SE) :
                                    (facing_left ? ORIENT_W  : ORIENT_E);
    endfunction

endpackage

// File: rtl/jump_fsm.sv
// jump_fsm: vertical jump/fall state machine with integer gravity, owns Y
module jump_fsm
    import game_pkg::*;
#(
    parameter int Y_MIN          = 0,
    parameter int GROUND_Y       = 100,
    parameter int JUMP_VELOCITY  = 6,
    parameter int MAX_FALL       = 6,
    parameter int GRAVITY_PERIOD = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       jreq,
    output logic [7:0] y,
    output vstate_t    state
);

    vstate_t    state_n;
    logic [7:0] vy, vy_n, gcnt, gcnt_n, y_n;
    logic [8:0] y_up, y_dn;
    logic       last;

    assign y_up = ({1'b0, y} < 9'(Y_MIN) + {1'b0, vy}) ? 9'(Y_MIN) : {1'b0, y} - {1'b0, vy};
    assign y_dn = {1'b0, y} + {1'b0, vy};
    assign last = gcnt == 8'(GRAVITY_PERIOD - 1);

    // State, speed, gravity counter and Y advance only on frame ticks
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= GROUNDED;
            vy    <= '0;
            gcnt  <= '0;
            y     <= 8'(GROUND_Y);
        end else begin
            state <= state_n;
            vy    <= vy_n;
            gcnt  <= gcnt_n;
            y     <= y_n;
        end
    end

    // Next-state: launch, decelerate while rising, accelerate while falling, land
    always_comb begin
        state_n = state;
        vy_n    = vy;
        gcnt_n  = gcnt;
        y_n     = y;
        if (tick) begin
            case (state)
                GROUNDED: if (jreq) begin
                    state_n = RISING;
                    vy_n    = 8'(JUMP_VELOCITY);
                    gcnt_n  = '0;
                end
                RISING: begin
                    y_n     = y_up[7:0];
                    gcnt_n  = last ? 8'd0 : gcnt + 8'd1;
                    vy_n    = last ? vy - 8'd1 : vy;
                    state_n = (last && vy == 8'd1) ? FALLING : RISING;
                end
                FALLING: if (y_dn >= 9'(GROUND_Y)) begin
                    y_n     = 8'(GROUND_Y);
                    state_n = GROUNDED;
                    vy_n    = '0;
                    gcnt_n  = '0;
                end else begin
                    y_n    = y_dn[7:0];
                    gcnt_n = last ? 8'd0 : gcnt + 8'd1;
                    vy_n   = (last && vy < 8'(MAX_FALL)) ? vy + 8'd1 : vy;
                end
                default: state_n = GROUNDED;
            endcase
        end
    end

endmodule

// File: rtl/player_motion.sv
// player_motion: per-frame walking, jump capture and status packing for the player sprite
module player_motion
    import game_pkg::*;
#(
    parameter int X_MIN          = 0,
    parameter int X_MAX          = 127,
    parameter int X_START        = 10,
    parameter int Y_MIN          = 0,
    parameter int GROUND_Y       = 100,
    parameter int JUMP_VELOCITY  = 6,
    parameter int MAX_FALL       = 6,
    parameter int GRAVITY_PERIOD = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    output logic [7:0] LocX_reg,
    output logic [7:0] LocY_reg,
    output logic [7:0] BotInfo_reg
);

    vstate_t    state;
    logic       jump_prev, jreq, facing_left, moving, go_right, go_left, jreq_eff, air;
    logic [7:0] x;

    assign go_right = btn_right & ~btn_left;
    assign go_left  = btn_left & ~btn_right;
    assign jreq_eff = jreq | (btn_jump & ~jump_prev);
    assign air      = state != GROUNDED;
    assign LocX_reg = x;

    jump_fsm #(
        .Y_MIN(Y_MIN),
        .GROUND_Y(GROUND_Y),
        .JUMP_VELOCITY(JUMP_VELOCITY),
        .MAX_FALL(MAX_FALL),
        .GRAVITY_PERIOD(GRAVITY_PERIOD)
    ) u_jump (
        .clk(clk),
        .reset(reset),
        .tick(tick),
        .jreq(jreq_eff),
        .y(LocY_reg),
        .state(state)
    );

    // Jump edges are captured every cycle; walking and facing advance on ticks
    always_ff @(posedge clk) begin
        if (reset) begin
            jump_prev   <= 1'b0;
            jreq        <= 1'b0;
            x           <= 8'(X_START);
            facing_left <= 1'b0;
            moving      <= 1'b0;
        end else begin
            jump_prev <= btn_jump;
            jreq      <= tick ? 1'b0 : jreq_eff;
            if (tick) begin
                x           <= (go_right && x < 8'(X_MAX)) ? x + 8'd1 :
                               (go_left && x > 8'(X_MIN))  ? x - 8'd1 : x;
                facing_left <= go_left ? 1'b1 : go_right ? 1'b0 : facing_left;
                moving      <= go_left | go_right;
            end
        end
    end

    // Status is a pure decode of tick-updated registers, so it is stable all frame
    always_comb begin
        BotInfo_reg                        = '0;
        BotInfo_reg[MOVE_MSB:MOVE_LSB]     = {3'b000, moving | air};
        BotInfo_reg[AIR_BIT]               = air;
        BotInfo_reg[ORIENT_MSB:ORIENT_LSB] = orient_code(state, facing_left);
    end

endmodule

// File: doc/player_motion.md
# player_motion

Frame-rate motion controller for the side-scroller player sprite. It sits directly upstream of the robot icon renderer. It turns debounced left, right and jump buttons into world-coordinate position (LocX_reg, LocY_reg) and status (BotInfo_reg), which the renderer uses to select and place sprite frames. All state advances once per frame tick, with horizontal walking, a jump/fall state machine and integer gravity.

## Interface
Parameters:
- X_MIN, 0 — left world bound, inclusive.
- X_MAX, 127 — right world bound, inclusive.
- X_START, 10 — X after reset.
- Y_MIN, 0 — top world bound; rising saturates here.
- GROUND_Y, 100 — ground row; also Y after reset.
- JUMP_VELOCITY, 6 — initial upward speed in rows/tick; must be in 1..GROUND_Y.
- MAX_FALL, 6 — terminal downward speed in rows/tick; must be ≥1.
- GRAVITY_PERIOD, 2 — ticks between each ±1 velocity change; must be ≥1.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle frame pulse (once per VGA frame).
- btn_left  in  1  debounced level, move left.
- btn_right  in  1  debounced level, move right.
- btn_jump  in  1  debounced level, jump.
- LocX_reg  out  8  world X, unsigned; zero-extended to 32 bits at the renderer.
- LocY_reg  out  8  world Y, unsigned.
- BotInfo_reg  out  8  status bits:
  - [7:4] movement: 1 = moving, 0 = still.
  - [3] airborne.
  - [2:0] orientation code: 0=N, 1=NE, 2=E, 3=SE, 4=S, 5=SW, 6=W, 7=NW.

## Operation
- Jump request:
  - A rising edge of btn_jump, detected every clk, sets the pending flag `jreq`.
  - `jreq` clears on every tick.
  - An edge in the same cycle as a tick counts for that tick.
  - A request seen while airborne is discarded; there is no double jump.
- Horizontal, evaluated on each tick:
  - dir = right when only btn_right is held; left when only btn_left is held; none when both or neither are held.
  - X moves ±1 per tick, saturating at X_MIN/X_MAX.
  - `facing` updates whenever dir ≠ none, including while pinned at a bound.
- Vertical FSM states: GROUNDED, RISING, FALLING. `vy` is a speed magnitude; `gcnt` counts ticks toward the next velocity change.
  - GROUNDED, tick with jreq: go to RISING, vy=JUMP_VELOCITY, gcnt=0. Y is unchanged on this tick.
  - RISING, each tick:
    - Y ← max(Y−vy, Y_MIN).
    - When gcnt = GRAVITY_PERIOD−1: gcnt←0 and vy←vy−1. If the new vy is 0, go to FALLING.
    - Otherwise gcnt+1.
  - FALLING, each tick:
    - If Y+vy ≥ GROUND_Y: Y←GROUND_Y, go to GROUNDED, vy←0, gcnt←0.
    - Else: Y←Y+vy. vy increments by 1 every GRAVITY_PERIOD ticks, saturating at MAX_FALL.
- Orientation:
  - GROUNDED: E or W, from facing.
  - RISING: NE or NW.
  - FALLING: SE or SW.
- BotInfo_reg[7:4] = 1 when dir ≠ none on the latest tick or when airborne; otherwise 0.
- Bits [3] and [7:4] derive from the post-update state.
- Internal arithmetic is 9 bits wide, so no wrap-around is possible before saturation.

## Timing
- Reset values:
  - LocX_reg = X_START, LocY_reg = GROUND_Y.
  - BotInfo_reg = 8'h02 (still, grounded, facing E).
  - State GROUNDED; vy, gcnt, jreq = 0; facing = E.
  - The button-edge history register is cleared.
- Reset has priority over tick. Reset during a jump returns to the reset values on the next edge.
- All outputs are registered. They update on the clk edge where tick=1 and are stable for the whole frame.
- No input is acted on between ticks except jump-edge capture.
- Back-to-back ticks (tick held high) are legal; the block performs one update per cycle.

## Structure
- Shared package `game_pkg`:
  - orientation constants ORIENT_N..ORIENT_NW.
  - vertical state enum.
  - BotInfo field positions (MOVE_MSB/LSB, AIR_BIT, ORIENT_MSB/LSB).
- One sub-module, `jump_fsm`: owns the vertical state, vy, gcnt and Y. It takes tick, jreq and reset, and outputs Y and state.
- The top level owns X, facing, jump-edge capture and BotInfo packing.

## Test plan
- Reset mid-jump, then release reset → X=10, Y=100, BotInfo=8'h02 on the first cycle after reset.
- Parameters JUMP_VELOCITY=4, GRAVITY_PERIOD=1, MAX_FALL=6, GROUND_Y=100; one jump edge, then 10 ticks → Y per tick: 100, 96, 93, 91, 90, 90, 91, 93, 96, 100. The final state is GROUNDED.
- btn_right held for 130 ticks from X=10 → X increments each tick and pins at 127; BotInfo=8'h12 throughout.
- btn_left and btn_right held together → X unchanged, BotInfo[7:4]=0, facing unchanged.
- Jump edge in the same cycle as a tick → BotInfo[3]=1 on the next cycle. A second edge while airborne is ignored, and there is no re-launch on landing.
- btn_left held during the rise and fall → orientation reads 7 (NW) while rising, 5 (SW) while falling and 6 (W) on landing.
